// File: rtl/ntr_cmd_queue.sv
// ntr_cmd_queue: synchronises ntr_ready, latches each command once, runs LED commands
// locally and queues all others in a FWFT FIFO. Optional counters: NTR_CMD_STATS_EN.
module ntr_cmd_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [7:0]  LED_OPCODE = 8'hFF,
    parameter int unsigned LED_BIT    = 56
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            ntr_command,
    input  logic                   ntr_ready,
    output logic [63:0]            cmd_data,
    output logic                   cmd_valid,
    input  logic                   cmd_pop,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   led,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [15:0]            cmd_total,
    output logic [7:0]             cmd_dropped
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_LOW,
        S_WAIT_RDY,
        S_CAPTURE,
        S_DISPATCH
    } state_t;

    state_t        state;
    logic          rdy_meta;
    logic          rdy_s;
    logic [63:0]   hold_reg;
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   level;
    logic          dispatch;
    logic          is_led;
    logic          space;
    logic          push;
    logic          pop;
    logic          drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= ntr_ready;
            rdy_s    <= rdy_meta;
        end
    end

    assign dispatch = (state == S_DISPATCH);
    assign is_led   = (hold_reg[7:0] == LED_OPCODE);
    assign pop      = cmd_pop && (level != '0);
    // A full FIFO still accepts the write when the head is popped in the same cycle.
    assign space    = (level < LVL_FULL) || cmd_pop;
    assign push     = dispatch && !is_led && space;
    assign drop     = dispatch && !is_led && !space;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_WAIT_LOW;
            hold_reg <= '0;
            led      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_WAIT_LOW: if (!rdy_s) state <= S_WAIT_RDY;
                S_WAIT_RDY: if (rdy_s) state <= S_CAPTURE;
                S_CAPTURE: begin
                    hold_reg <= ntr_command;
                    state    <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (is_led) led <= hold_reg[LED_BIT];
                    state <= S_WAIT_LOW;
                end
                default: state <= S_WAIT_LOW;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= hold_reg;
    end

    assign cmd_valid  = (level != '0);
    assign cmd_data   = cmd_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

`ifdef NTR_CMD_STATS_EN
    logic [15:0] total_q;
    logic [7:0]  dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (dispatch) total_q <= total_q + 16'd1;
            if (drop && (dropped_q != '1)) dropped_q <= dropped_q + 8'd1;
        end
    end

    assign cmd_total   = total_q;
    assign cmd_dropped = dropped_q;
`else
    assign cmd_total   = '0;
    assign cmd_dropped = '0;
`endif

endmodule

// File: doc/ntr_cmd_queue.md
Name: ntr_cmd_queue

Overview:
Consumer stage directly downstream of the ntr bus capture block. Takes the 64-bit command and ready flag from the capture block, synchronises ready into the system clock domain, and latches each command once. LED-control commands are executed internally. All other commands are buffered in a first-word-fall-through FIFO for the rest of the design, which consumes them with a valid/pop handshake.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2, range 2..16
LED_OPCODE, 8'hFF, value of ntr_command[7:0] that selects the internal LED command
LED_BIT, 56, bit index of ntr_command that supplies the new LED value

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
ntr_command  input  64  command word from the capture block; stable while ntr_ready=1
ntr_ready  input  1  command-complete flag from the capture block; asynchronous to clk
cmd_data  output  64  FIFO head entry; 64'h0 when the FIFO is empty
cmd_valid  output  1  FIFO non-empty
cmd_pop  input  1  consumer accepts cmd_data this cycle
fifo_level  output  $clog2(DEPTH)+1  number of occupied entries
led  output  1  LED register
overflow  output  1  sticky: a command was dropped because the FIFO was full
clear_overflow  input  1  clears overflow
cmd_total  output  16  commands received (see Optional Feature)
cmd_dropped  output  8  commands dropped (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a clk edge:
  - cmd_valid=0, cmd_data=0, fifo_level=0, led=0, overflow=0, cmd_total=0, cmd_dropped=0.
  - Read/write pointers cleared; both synchroniser flops cleared.
  - FSM goes to S_WAIT_LOW.
- Synchroniser: two flops on ntr_ready produce rdy_s. ntr_command is not synchronised; it is sampled only in S_CAPTURE, by which point it is guaranteed stable.
- FSM:
  - S_WAIT_LOW: stay while rdy_s=1; go to S_WAIT_RDY when rdy_s=0. Because reset enters this state, a command whose ready is held high across reset is ignored.
  - S_WAIT_RDY: go to S_CAPTURE when rdy_s=1.
  - S_CAPTURE: hold_reg <= ntr_command; go to S_DISPATCH.
  - S_DISPATCH: one cycle, then go to S_WAIT_LOW. Actions:
    - If hold_reg[7:0]==LED_OPCODE: led <= hold_reg[LED_BIT]. Nothing is written to the FIFO.
    - Otherwise, if there is space: write hold_reg at the write pointer.
    - Otherwise: drop the command and set overflow.
- Latency: ntr_ready sampled high at edge 1 gives cmd_valid=1 after edge 5 (2 synchroniser edges + WAIT_RDY + CAPTURE + DISPATCH). An LED command updates led after edge 5.
- Exactly one capture per ntr_ready pulse, however long it is held high. A pulse shorter than 3 clk periods may be missed; the capture block guarantees it holds ntr_ready longer than that.
- FIFO:
  - First-word-fall-through; cmd_data = head entry whenever cmd_valid=1.
  - cmd_pop while cmd_valid=1 advances the read pointer; cmd_pop while empty is ignored, with no state change.
  - Space condition: fifo_level<DEPTH, or fifo_level==DEPTH with cmd_pop=1 in the same cycle. In the latter case push and pop both occur and the level stays at DEPTH.
  - Push and pop in the same cycle at any level: the level is unchanged.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- overflow:
  - Set in S_DISPATCH on a drop.
  - Cleared by clear_overflow=1.
  - If a drop and clear_overflow=1 occur in the same cycle, set wins.
- LED commands are never dropped and never affect fifo_level.

Optional Feature:
- Macro: NTR_CMD_STATS_EN.
- Defined:
  - cmd_total increments once per S_DISPATCH, for both LED and queued commands; wraps at 16'hFFFF -> 0.
  - cmd_dropped increments on each drop; saturates at 8'hFF.
  - Both counters clear on rst only.
- Undefined: cmd_total and cmd_dropped are tied to constant 0 and no counter logic is generated. The ports are present in both builds.

Test Plan:
- Reset: rst for 2 cycles with ntr_ready=1 held and command 64'h0123456789ABCD01 -> no capture; cmd_valid=0, led=0. Drop ntr_ready, then pulse it high for 6 cycles -> cmd_valid=1 after edge 5, cmd_data=64'h0123456789ABCD01, fifo_level=1.
- LED command: ntr_command=64'h01000000000000FF, ntr_ready pulse -> led=1, fifo_level stays 0. Then 64'h00000000000000FF -> led=0.
- Order and wrap: 6 commands, with cmd_pop after each one arrives -> data emerges in order 1..6 across pointer wrap at DEPTH=4; fifo_level never exceeds 1.
- Overflow: 5 non-LED commands with no pops -> fifo_level=4, overflow=1, command 5 absent. With NTR_CMD_STATS_EN: cmd_total=5, cmd_dropped=1. clear_overflow pulse -> overflow=0.
- Full with simultaneous pop: FIFO full, cmd_pop=1 during the S_DISPATCH cycle of a new command -> no drop, fifo_level stays 4, new entry is at the tail.
- Long ready: ntr_ready held high for 50 cycles -> exactly one capture; cmd_total increments by 1 (stats build).
